// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, ALU classes and PC sources.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11,
        StTrap     = 4'd12
    } state_t;

    localparam logic [5:0] OpR    = 6'd0;
    localparam logic [5:0] OpLw   = 6'd35;
    localparam logic [5:0] OpSw   = 6'd43;
    localparam logic [5:0] OpBeq  = 6'd4;
    localparam logic [5:0] OpJ    = 6'd2;
    localparam logic [5:0] OpAddi = 6'd8;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] PcSrcAlu  = 2'b00;
    localparam logic [1:0] PcSrcOut  = 2'b01;
    localparam logic [1:0] PcSrcJump = 2'b10;

    localparam int unsigned CountWidth = 16;

    // States whose exit to FETCH completes an instruction.
    function automatic logic is_retire_state(state_t s);
        return (s == StRWb) || (s == StMemWb) || (s == StAddiWb) ||
               (s == StBranch) || (s == StJump) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/mc_inst_counter.sv
// Retired-instruction counter; wraps silently at the top of its range.
module mc_inst_counter
    import mc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [CountWidth-1:0] count
);

    logic [CountWidth-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM: next-state, datapath strobes and retire tracking.
module multi_cycle_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Inst_31_26,
    input  logic        Mem_Ready,
    output logic        PC_Write,
    output logic        PC_Write_Cond,
    output logic        I_or_D,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        IR_Write,
    output logic        Mem_to_Reg,
    output logic        Reg_Dst,
    output logic        Reg_Write,
    output logic        ALU_Src_A,
    output logic [1:0]  ALU_Src_B,
    output logic [1:0]  ALU_Op,
    output logic [1:0]  PC_Source,
    output logic [3:0]  State,
    output logic        Illegal_Op,
    output logic [15:0] Inst_Count
);

    state_t state_q, state_d;
    logic   illegal_q;
    logic   retire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StTrap) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (Mem_Ready) state_d = StDecode;
            StDecode: begin
                case (Inst_31_26)
                    OpR:        state_d = StExecute;
                    OpLw, OpSw: state_d = StMemAddr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiExec;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAddr:  state_d = (Inst_31_26 == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  if (Mem_Ready) state_d = StMemWb;
            StMemWrite: if (Mem_Ready) state_d = StFetch;
            StExecute:  state_d = StRWb;
            StAddiExec: state_d = StAddiWb;
            StRWb, StMemWb, StAddiWb, StBranch, StJump: state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
    end

    assign retire = (state_d == StFetch) && is_retire_state(state_q);

    // Outputs held at zero while reset is low so no write can slip through.
    always_comb begin
        PC_Write      = 1'b0;
        PC_Write_Cond = 1'b0;
        I_or_D        = 1'b0;
        Mem_Read      = 1'b0;
        Mem_Write     = 1'b0;
        IR_Write      = 1'b0;
        Mem_to_Reg    = 1'b0;
        Reg_Dst       = 1'b0;
        Reg_Write     = 1'b0;
        ALU_Src_A     = 1'b0;
        ALU_Src_B     = 2'b00;
        ALU_Op        = AluAdd;
        PC_Source     = PcSrcAlu;
        if (reset) begin
            case (state_q)
                StFetch: begin
                    Mem_Read  = 1'b1;
                    ALU_Src_B = 2'b01;
                    IR_Write  = Mem_Ready;
                    PC_Write  = Mem_Ready;
                end
                StDecode:  ALU_Src_B = 2'b11;
                StMemAddr, StAddiExec: begin
                    ALU_Src_A = 1'b1;
                    ALU_Src_B = 2'b10;
                end
                StMemRead: begin
                    Mem_Read = 1'b1;
                    I_or_D   = 1'b1;
                end
                StMemWrite: begin
                    Mem_Write = 1'b1;
                    I_or_D    = 1'b1;
                end
                StMemWb: begin
                    Reg_Write  = 1'b1;
                    Mem_to_Reg = 1'b1;
                end
                StExecute: begin
                    ALU_Src_A = 1'b1;
                    ALU_Op    = AluFunct;
                end
                StRWb: begin
                    Reg_Write = 1'b1;
                    Reg_Dst   = 1'b1;
                end
                StAddiWb:  Reg_Write = 1'b1;
                StBranch: begin
                    ALU_Src_A     = 1'b1;
                    ALU_Op        = AluSub;
                    PC_Write_Cond = 1'b1;
                    PC_Source     = PcSrcOut;
                end
                StJump: begin
                    PC_Write  = 1'b1;
                    PC_Source = PcSrcJump;
                end
                default: ;
            endcase
        end
    end

    mc_inst_counter u_inst_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .count (Inst_Count)
    );

    assign State      = state_q;
    assign Illegal_Op = illegal_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: per-cycle state/strobe scoreboard and counter wrap.
module tb_multi_cycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal_op;
    logic [15:0] inst_count;

    logic        wrap_rst;
    logic        wrap_inc;
    logic [15:0] wrap_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    multi_cycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .Inst_31_26    (op),
        .Mem_Ready     (mem_ready),
        .PC_Write      (pc_write),
        .PC_Write_Cond (pc_write_cond),
        .I_or_D        (i_or_d),
        .Mem_Read      (mem_read),
        .Mem_Write     (mem_write),
        .IR_Write      (ir_write),
        .Mem_to_Reg    (mem_to_reg),
        .Reg_Dst       (reg_dst),
        .Reg_Write     (reg_write),
        .ALU_Src_A     (alu_src_a),
        .ALU_Src_B     (alu_src_b),
        .ALU_Op        (alu_op),
        .PC_Source     (pc_source),
        .State         (state),
        .Illegal_Op    (illegal_op),
        .Inst_Count    (inst_count)
    );

    mc_inst_counter u_wrap (
        .clk   (clk),
        .reset (wrap_rst),
        .inc   (wrap_inc),
        .count (wrap_count)
    );

    logic [15:0] act_ctrl;
    assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    typedef struct {
        logic [5:0] op;
        int         len;
        int         tr [8];
    } vec_t;

    typedef struct {
        int          st;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb [$];
    vec_t vecs [9];

    // Reference strobe table, same bit order as act_ctrl.
    function automatic logic [15:0] exp_ctrl(int s, logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
        srcb = 2'b00;
        aop  = 2'b00;
        pcs  = 2'b00;
        case (s)
            0:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1'b1; srcb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin srca = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rdst = 1'b1; end
            8:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            9:  begin pcw = 1'b1; pcs = 2'b10; end
            10: begin srca = 1'b1; srcb = 2'b10; end
            11: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Starts and ends just after a falling edge. Mem_Ready is low exactly where the
    // trace repeats a state; tail_mr drives the final cycle.
    task automatic run(input vec_t v, input logic tail_mr, input int retires);
        logic mr [8];
        exp_t e;
        check("count_before", 32'(inst_count), 32'(exp_cnt));
        for (int i = 0; i < v.len; i++) begin
            mr[i] = (i + 1 < v.len) ? (v.tr[i + 1] != v.tr[i]) : tail_mr;
            e.st = v.tr[i];
            e.ctrl = exp_ctrl(v.tr[i], mr[i]);
            sb.push_back(e);
        end
        for (int i = 0; i < v.len; i++) begin
            op = v.op;
            mem_ready = mr[i];
            #1;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("state", 32'(state), 32'(e.st));
                check("ctrl", 32'(act_ctrl), 32'(e.ctrl));
            end
            @(negedge clk);
        end
        exp_cnt = (exp_cnt + retires) & 16'hFFFF;
    endtask

    initial begin
        vec_t v;
        reset = 1'b0;
        mem_ready = 1'b1;
        op = 6'd0;
        wrap_rst = 1'b0;
        wrap_inc = 1'b0;

        vecs[0] = '{op: 6'd0,  len: 4, tr: '{0, 1, 6, 7, 0, 0, 0, 0}};
        vecs[1] = '{op: 6'd8,  len: 4, tr: '{0, 1, 10, 11, 0, 0, 0, 0}};
        vecs[2] = '{op: 6'd4,  len: 3, tr: '{0, 1, 8, 0, 0, 0, 0, 0}};
        vecs[3] = '{op: 6'd2,  len: 3, tr: '{0, 1, 9, 0, 0, 0, 0, 0}};
        vecs[4] = '{op: 6'd43, len: 4, tr: '{0, 1, 2, 5, 0, 0, 0, 0}};
        vecs[5] = '{op: 6'd35, len: 5, tr: '{0, 1, 2, 3, 4, 0, 0, 0}};
        vecs[6] = '{op: 6'd35, len: 7, tr: '{0, 1, 2, 3, 3, 3, 4, 0}};
        vecs[7] = '{op: 6'd43, len: 7, tr: '{0, 0, 0, 1, 2, 5, 5, 0}};
        vecs[8] = '{op: 6'd0,  len: 5, tr: '{0, 0, 1, 6, 7, 0, 0, 0}};

        // Reset with Mem_Ready high: FETCH strobes must still be suppressed.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(inst_count), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_ctrl", 32'(act_ctrl), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 9; k++) begin
            run(vecs[k], 1'b1, 1);
        end
        check("illegal_clear", 32'(illegal_op), 32'd0);

        // Reset asserted while MEM_READ is stalled.
        v = '{op: 6'd35, len: 5, tr: '{0, 1, 2, 3, 3, 0, 0, 0}};
        run(v, 1'b0, 0);
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_ctrl", 32'(act_ctrl), 32'd0);
        @(negedge clk);
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_count", 32'(inst_count), 32'd0);
        check("midrst_ctrl2", 32'(act_ctrl), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        run(vecs[3], 1'b1, 1);

        // Illegal opcode: TRAP is sticky and does not retire.
        v = '{op: 6'h3F, len: 3, tr: '{0, 1, 12, 0, 0, 0, 0, 0}};
        run(v, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            #1;
            check("trap_state", 32'(state), 32'd12);
            check("trap_illegal", 32'(illegal_op), 32'd1);
            check("trap_ctrl", 32'(act_ctrl), 32'd0);
            @(negedge clk);
        end
        check("trap_count", 32'(inst_count), 32'(exp_cnt));
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("trap_rst_illegal", 32'(illegal_op), 32'd0);
        check("trap_rst_state", 32'(state), 32'd0);

        // Counter wrap at 0xFFFF, exercised on a standalone counter instance.
        @(negedge clk);
        check("wrap_init", 32'(wrap_count), 32'd0);
        wrap_rst = 1'b1;
        wrap_inc = 1'b1;
        repeat (65535) @(negedge clk);
        check("wrap_ffff", 32'(wrap_count), 32'h0000_FFFF);
        @(negedge clk);
        check("wrap_zero", 32'(wrap_count), 32'd0);
        wrap_inc = 1'b0;
        @(negedge clk);
        check("wrap_hold", 32'(wrap_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
